// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter slice.
//   ramstate_t      : RAM handshake status returned with every cycle
//   arb_state_t     : arbiter FSM states
//   word_t          : 32-bit data/address word
//   BADWORD_DEFAULT : load value substituted when an access fails or times out
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } arb_state_t;

  localparam word_t BADWORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_timeout.sv
// Access-duration counter for the memory arbiter.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : forces the count back to zero (arbiter idle)
//   enable    : counts one cycle spent in an access state
//   expired   : count has reached TIMEOUT-1, i.e. this is the last allowed access cycle
module arb_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  // Saturates at 255 rather than wrapping; in practice the arbiter leaves the
  // access state at LAST so the ceiling is never reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Registered arbiter between instruction-fetch and data ports and one RAM port.
// Only one request is in flight; data requests win over fetches. RAM-side
// outputs come straight from flops so the RAM sees stable address/data/enables
// for the whole access, and a hung RAM is turned into a BADWORD error response.
// Ports:
//   CLK, nRST              : clock, asynchronous active-low reset
//   iREN, iaddr            : fetch request / word address (held until iwait drops)
//   iwait, iload           : fetch pending / fetched word
//   dREN, dWEN             : data read / write request (held until dwait drops)
//   daddr, dstore          : data address / write data
//   dwait, dload           : data pending / read data
//   memREN, memWEN         : RAM enables
//   memaddr, memstore      : RAM address / write data
//   ramload, ramstate      : RAM read data / handshake status
//   merr                   : sticky error flag, cleared only by reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; next request is captured here
// DACC  | data access on the RAM, waiting for ACCESS/ERROR/timeout
// IACC  | fetch access on the RAM, waiting for ACCESS/ERROR/timeout
// DRESP | data response cycle: dwait low for exactly this cycle
// IRESP | fetch response cycle: iwait low for exactly this cycle
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter word_t       BADWORD = BADWORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        memREN,
  output logic        memWEN,
  output logic [31:0] memaddr,
  output logic [31:0] memstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  arb_state_t state_q, state_d;
  word_t      req_addr_q, req_addr_d;
  word_t      req_store_q, req_store_d;
  logic       req_write_q, req_write_d;
  logic       mem_ren_q, mem_ren_d;
  logic       mem_wen_q, mem_wen_d;
  word_t      iload_q, iload_d;
  word_t      dload_q, dload_d;
  logic       merr_q, merr_d;

  ramstate_t  ram_st;
  logic       tmo_clear, tmo_enable, tmo_expired;
  logic       in_access;

  assign ram_st     = ramstate_t'(ramstate);
  assign in_access  = (state_q == DACC) || (state_q == IACC);
  // IDLE always precedes an access state, so clearing there gives a zero
  // count on the first access cycle.
  assign tmo_clear  = (state_q == IDLE);
  assign tmo_enable = in_access;

  arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_store_d = req_store_q;
    req_write_d = req_write_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    iload_d     = iload_q;
    dload_d     = dload_q;
    merr_d      = merr_q;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read and write request is served as a write.
        if (dWEN || dREN) begin
          state_d     = DACC;
          req_addr_d  = daddr;
          req_store_d = dstore;
          req_write_d = dWEN;
          mem_wen_d   = dWEN;
          mem_ren_d   = !dWEN;
        end else if (iREN) begin
          state_d     = IACC;
          req_addr_d  = iaddr;
          req_write_d = 1'b0;
          mem_ren_d   = 1'b1;
        end
      end

      DACC, IACC: begin
        mem_ren_d = mem_ren_q;
        mem_wen_d = mem_wen_q;
        // ACCESS is honoured even on the last allowed cycle.
        if (ram_st == ACCESS) begin
          if (!req_write_q) begin
            if (state_q == DACC) dload_d = ramload;
            else                 iload_d = ramload;
          end
          state_d   = (state_q == DACC) ? DRESP : IRESP;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
        end else if ((ram_st == ERROR) || tmo_expired) begin
          if (!req_write_q) begin
            if (state_q == DACC) dload_d = BADWORD;
            else                 iload_d = BADWORD;
          end
          merr_d    = 1'b1;
          state_d   = (state_q == DACC) ? DRESP : IRESP;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
        end
      end

      DRESP, IRESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_store_q <= '0;
      req_write_q <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      iload_q     <= '0;
      dload_q     <= '0;
      merr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_store_q <= req_store_d;
      req_write_q <= req_write_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      merr_q      <= merr_d;
    end
  end

  assign memREN   = mem_ren_q;
  assign memWEN   = mem_wen_q;
  assign memaddr  = req_addr_q;
  assign memstore = req_store_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign merr     = merr_q;

  // Wait follows the request line except during that port's response cycle.
  assign iwait = iREN && (state_q != IRESP);
  assign dwait = (dREN || dWEN) && (state_q != DRESP);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int    TO  = 4;
  localparam word_t BAD = 32'hBAD1BAD1;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0;
  logic      iwait, dwait, memREN, memWEN, merr;
  word_t     iload, dload, memaddr, memstore;
  word_t     ramload = '0;
  ramstate_t ramstate = FREE;

  mem_arbiter #(.TIMEOUT(TO), .BADWORD(BAD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  // k = access cycle on which the RAM answers (0 = never answers)
  typedef struct { int k; bit err_out; word_t addr; bit write; word_t store; } plan_t;
  typedef struct { bit is_i; int cyc; word_t dl; word_t il; bit me; } exp_t;

  plan_t ram_q[$];
  exp_t  exp_q[$];
  word_t ram_mem   [word_t];
  word_t model_mem [word_t];

  int    compared = 0, mismatched = 0;
  int    cyc = 0;
  word_t m_dload = '0, m_iload = '0;
  bit    m_merr = 1'b0;

  function automatic word_t dflt(word_t a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  task automatic chk(string name, word_t act, word_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Behavioural RAM: answers each access according to the plan queued by the driver.
  initial begin
    plan_t cur;
    bit    active;
    int    j;
    active = 1'b0;
    j = 0;
    cur = '{k:0, err_out:1'b0, addr:'0, write:1'b0, store:'0};
    forever begin
      @(negedge CLK);
      if (nRST !== 1'b1 || !(memREN || memWEN)) begin
        active   = 1'b0;
        ramstate = FREE;
        ramload  = $urandom;
      end else begin
        if (!active) begin
          active = 1'b1;
          j = 0;
          if (ram_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_ram_access: got addr %h expected no access", memaddr);
            cur = '{k:0, err_out:1'b0, addr:memaddr, write:memWEN, store:memstore};
          end else begin
            cur = ram_q.pop_front();
          end
        end
        j++;
        chk("memaddr", memaddr, cur.addr);
        chk("memWEN", word_t'(memWEN), word_t'(cur.write));
        chk("memREN", word_t'(memREN), word_t'(!cur.write));
        if (cur.write) chk("memstore", memstore, cur.store);
        if (cur.k != 0 && j == cur.k) begin
          if (cur.err_out) begin
            ramstate = ERROR;
            ramload  = $urandom;
          end else begin
            ramstate = ACCESS;
            if (cur.write) begin
              ram_mem[cur.addr] = cur.store;
              ramload = $urandom;
            end else begin
              ramload = ram_mem.exists(cur.addr) ? ram_mem[cur.addr] : dflt(cur.addr);
            end
          end
        end else begin
          ramstate = BUSY;
          ramload  = $urandom;
        end
      end
    end
  end

  task automatic take(bit is_i);
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL unexpected_response: got port %0d response expected none", is_i);
    end else begin
      e = exp_q.pop_front();
      chk("resp_port", word_t'(is_i), word_t'(e.is_i));
      chk("resp_cycle", word_t'(cyc), word_t'(e.cyc));
      chk("dload", dload, e.dl);
      chk("iload", iload, e.il);
      chk("merr", word_t'(merr), word_t'(e.me));
    end
  endtask

  // Monitor: every completed handshake is checked against the scoreboard head.
  initial forever begin
    @(negedge CLK);
    if (nRST === 1'b1) begin
      if ((dREN || dWEN) && !dwait) take(1'b0);
      if (iREN && !iwait) take(1'b1);
    end
  end

  // Reference model: outcome and completion cycle from the access rules.
  task automatic predict(input bit is_i, input bit wr, input word_t addr, input word_t store,
                         input int k, input bit err_out, input int start, output int done_cyc);
    int    eff;
    bit    err;
    word_t v;
    eff = (k >= 1 && k <= TO) ? k : TO;
    err = (k == 0) || (k > TO) || err_out;
    if (err) begin
      m_merr = 1'b1;
      v = BAD;
    end else if (wr) begin
      model_mem[addr] = store;
      v = '0;
    end else begin
      v = model_mem.exists(addr) ? model_mem[addr] : dflt(addr);
    end
    if (!wr) begin
      if (is_i) m_iload = v;
      else      m_dload = v;
    end
    ram_q.push_back('{k:k, err_out:err_out, addr:addr, write:wr, store:store});
    done_cyc = start + eff + 1;
    exp_q.push_back('{is_i:is_i, cyc:done_cyc, dl:m_dload, il:m_iload, me:m_merr});
  endtask

  task automatic serve();
    bit dpend, ipend, dd, id;
    int budget;
    dpend  = dREN || dWEN;
    ipend  = iREN;
    budget = 60;
    while ((dpend || ipend) && budget > 0) begin
      @(negedge CLK);
      dd = dpend && !dwait;
      id = ipend && !iwait;
      @(posedge CLK);
      #1;
      if (dd) begin dREN = 1'b0; dWEN = 1'b0; dpend = 1'b0; end
      if (id) begin iREN = 1'b0; ipend = 1'b0; end
      budget--;
    end
    if (dpend || ipend) begin
      compared++; mismatched++;
      $display("FAIL serve_timeout: got wait still high after 60 cycles expected completion");
      summary();
      $finish;
    end
  endtask

  // Called #1 after a rising edge with the arbiter idle.
  task automatic issue(bit do_d, bit wr, bit rd_too, word_t da, word_t ds, int kd, bit ed,
                       bit do_i, word_t ia, int ki, bit ei);
    int c, dc, ic, start;
    c = cyc;
    start = c;
    if (do_d) begin
      predict(1'b0, wr, da, ds, kd, ed, c, dc);
      start = dc + 1;
    end
    if (do_i) predict(1'b1, 1'b0, ia, '0, ki, ei, start, ic);
    daddr  = da;
    dstore = ds;
    dWEN   = do_d && wr;
    dREN   = do_d && (!wr || rd_too);
    iaddr  = ia;
    iREN   = do_i;
    serve();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    #2;
    chk("rst_memREN", word_t'(memREN), 0);
    chk("rst_memWEN", word_t'(memWEN), 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memstore", memstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_merr", word_t'(merr), 0);
    chk("rst_dwait_idle", word_t'(dwait), 0);
    chk("rst_iwait_idle", word_t'(iwait), 0);
    dREN = 1'b1; iREN = 1'b1;
    #1;
    chk("rst_dwait_req", word_t'(dwait), 1);
    chk("rst_iwait_req", word_t'(iwait), 1);
    dREN = 1'b0; iREN = 1'b0;
    #10 nRST = 1'b1;
    @(posedge CLK); #1;

    // single read, ACCESS on second access cycle
    ram_mem[32'h40]   = 32'hDEADBEEF;
    model_mem[32'h40] = 32'hDEADBEEF;
    issue(1, 0, 0, 32'h40, '0, 2, 0, 0, '0, 0, 0);
    // write; dload must be unchanged
    issue(1, 1, 0, 32'h80, 32'h12345678, 3, 0, 0, '0, 0, 0);
    // write with dREN also high is a write
    issue(1, 1, 1, 32'h84, 32'hCAFEF00D, 1, 0, 0, '0, 0, 0);
    // contention: data first, then fetch of 0x4
    issue(1, 0, 0, 32'h80, '0, 2, 0, 1, 32'h4, 2, 0);
    // ERROR on first access cycle
    issue(1, 0, 0, 32'h40, '0, 1, 1, 0, '0, 0, 0);
    // RAM hangs on a fetch: timeout response
    issue(0, 0, 0, '0, '0, 0, 0, 1, 32'h8, 0, 0);
    // ACCESS on the last allowed cycle still succeeds
    issue(1, 0, 0, 32'h84, '0, TO, 0, 0, '0, 0, 0);

    // reset in the middle of a data access
    ram_q.push_back('{k:0, err_out:1'b0, addr:32'h40, write:1'b0, store:'0});
    daddr = 32'h40; dREN = 1'b1;
    repeat (2) @(posedge CLK);
    #3 nRST = 1'b0;
    #1;
    chk("midrst_memREN", word_t'(memREN), 0);
    chk("midrst_memWEN", word_t'(memWEN), 0);
    chk("midrst_dload", dload, 0);
    chk("midrst_iload", iload, 0);
    chk("midrst_merr", word_t'(merr), 0);
    chk("midrst_dwait", word_t'(dwait), 1);
    dREN = 1'b0;
    exp_q.delete();
    m_merr = 1'b0; m_dload = '0; m_iload = '0;
    @(posedge CLK); #2 nRST = 1'b1;
    @(posedge CLK); #1;
    issue(1, 0, 0, 32'h40, '0, 2, 0, 0, '0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      int    mode, kd, ki, r;
      bit    wr, rd_too, ed, ei;
      word_t da, ds, ia;
      mode   = $urandom_range(0, 2);
      wr     = ($urandom_range(0, 2) == 0);
      rd_too = $urandom_range(0, 1);
      da     = word_t'($urandom_range(0, 15)) << 2;
      ia     = word_t'($urandom_range(0, 15)) << 2;
      ds     = $urandom;
      r  = $urandom_range(0, 9);
      kd = (r == 0) ? 0 : $urandom_range(1, TO + 2);
      r  = $urandom_range(0, 9);
      ki = (r == 0) ? 0 : $urandom_range(1, TO + 2);
      ed = ($urandom_range(0, 7) == 0);
      ei = ($urandom_range(0, 7) == 0);
      issue(mode != 1, wr, rd_too, da, ds, kd, ed, mode != 0, ia, ki, ei);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    repeat (4) @(posedge CLK);
    #1;
    chk("scoreboard_drained", word_t'(exp_q.size()), 0);
    chk("ram_plans_drained", word_t'(ram_q.size()), 0);
    summary();
    $finish;
  end

endmodule
